// File: rtl/comp_pkg.sv
// Shared types for the digit-serial magnitude comparator: FSM states and
// bit positions of the one-hot result vector.
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int GT = 2;
    localparam int LT = 1;
    localparam int EQ = 0;

endpackage

// File: rtl/comp_slice.sv
// Combinational unsigned comparator for one DIGIT-bit slice.
module comp_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/comp_seq.sv
// Digit-serial magnitude comparator: examines DIGIT bits per cycle from the
// MSB down and stops at the first unequal slice.
//
// state | meaning
// IDLE  | waiting for start; operands and mode captured on acceptance
// BUSY  | comparing the top slice of the working registers
// DONE  | y carries a fresh result; done pulses for this one cycle
module comp_seq
    import comp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [2:0]       y
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] wa, wa_n;
    logic [WIDTH-1:0] wb, wb_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [2:0]       y_n;
    logic [WIDTH-1:0] msk;
    logic             s_gt, s_lt, s_eq;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign msk = {signed_mode, {(WIDTH-1){1'b0}}};

    comp_slice #(.DIGIT(DIGIT)) u_slice (
        .a  (wa[WIDTH-1 -: DIGIT]),
        .b  (wb[WIDTH-1 -: DIGIT]),
        .gt (s_gt),
        .lt (s_lt),
        .eq (s_eq)
    );

    always_comb begin
        state_n = state;
        wa_n    = wa;
        wb_n    = wb;
        cnt_n   = cnt;
        y_n     = y;
        case (state)
            IDLE: begin
                if (start) begin
                    wa_n    = a ^ msk;
                    wb_n    = b ^ msk;
                    cnt_n   = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (!s_eq) begin
                    y_n     = '0;
                    y_n[GT] = s_gt;
                    y_n[LT] = s_lt;
                    state_n = DONE;
                end else if (cnt == LAST) begin
                    y_n     = '0;
                    y_n[EQ] = 1'b1;
                    state_n = DONE;
                end else begin
                    wa_n  = wa << DIGIT;
                    wb_n  = wb << DIGIT;
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // busy/done are flopped from the next state so every output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wa    <= '0;
            wb    <= '0;
            cnt   <= '0;
            y     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            wa    <= wa_n;
            wb    <= wb_n;
            cnt   <= cnt_n;
            y     <= y_n;
            busy  <= (state_n == BUSY);
            done  <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_comp_seq.sv
// Scoreboard bench for comp_seq: stimulus pushes expected result and timing,
// a monitor checks busy/done/y every cycle against the queue head.
module tb_comp_seq;

    localparam int WIDTH  = 16;
    localparam int DIGIT  = 4;
    localparam int NSLICE = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             signed_mode = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [2:0]       y;

    comp_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .y           (y)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] y;
        int         busy_from;
        int         busy_to;
        int         done_cyc;
    } exp_t;

    exp_t       q[$];
    logic [2:0] model_y = 3'b000;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_y(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                         input logic sm);
        logic signed [WIDTH-1:0] sa, sb;
        sa = ra;
        sb = rb;
        if (sm) begin
            if (sa > sb) return 3'b100;
            if (sa < sb) return 3'b010;
            return 3'b001;
        end
        if (ra > rb) return 3'b100;
        if (ra < rb) return 3'b010;
        return 3'b001;
    endfunction

    // Slices examined = position of the first differing digit from the top.
    function automatic int ref_k(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb);
        logic [WIDTH-1:0] d;
        d = ra ^ rb;
        for (int i = 0; i < NSLICE; i++) begin
            if (d[WIDTH-1-i*DIGIT -: DIGIT] != '0) return i + 1;
        end
        return NSLICE;
    endfunction

    // Monitor: samples just after each rising edge.
    initial begin
        logic exp_busy, exp_done;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                q.delete();
                model_y = 3'b000;
            end
            exp_busy = (q.size() > 0) && (cyc >= q[0].busy_from) && (cyc <= q[0].busy_to);
            exp_done = (q.size() > 0) && (cyc == q[0].done_cyc);
            chk("busy", {2'b00, busy}, {2'b00, exp_busy});
            chk("done", {2'b00, done}, {2'b00, exp_done});
            if (exp_done) begin
                chk("y_result", y, q[0].y);
                model_y = q[0].y;
                void'(q.pop_front());
            end else begin
                chk("y_hold", y, model_y);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout cyc=%0d actual=pending expected=drained", cyc);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic push_and_start(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                  input logic sm);
        exp_t e;
        int   k;
        k = ref_k(ta, tb_);
        e.y = ref_y(ta, tb_, sm);
        e.busy_from = cyc + 1;
        e.busy_to   = cyc + k;
        e.done_cyc  = cyc + k + 1;
        q.push_back(e);
        a = ta;
        b = tb_;
        signed_mode = sm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        signed_mode = 1'($urandom);
    endtask

    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic sm);
        push_and_start(ta, tb_, sm);
        wait_idle();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(16'h1234, 16'h1234, 1'b0);
        issue(16'h8000, 16'h7FFF, 1'b0);
        issue(16'h8000, 16'h7FFF, 1'b1);
        issue(16'h1235, 16'h1234, 1'b0);
        issue(16'hFFFF, 16'hFFFE, 1'b1);
        issue(16'h0000, 16'hFFFF, 1'b0);
        issue(16'h0000, 16'hFFFF, 1'b1);

        // Start pulsed mid-compare with different operands must be ignored.
        push_and_start(16'h1234, 16'h1230, 1'b0);
        a = 16'hFFFF;
        b = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        // Reset in cycle 2 of a four-slice compare: no done, outputs cleared.
        push_and_start(16'h4321, 16'h4321, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_idle();

        // Start coinciding with reset is discarded.
        rst = 1'b1;
        push_and_start(16'h9000, 16'h1000, 1'b0);
        rst = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        issue(16'h0005, 16'h0007, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                default: ;
            endcase
            push_and_start(ra, rb, 1'($urandom));
            wait_idle();
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/comp_seq.md
COMP_SEQ -- requirements
Module: comp_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4: bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT, with NSLICE = WIDTH/DIGIT.
REQ-003 Port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request a compare; sampled only in IDLE.
REQ-006 Port signed_mode, input, 1 bit: 1 = two's-complement compare, 0 = unsigned; latched with start.
REQ-007 Port a, input, WIDTH bits: operand A; latched with start.
REQ-008 Port b, input, WIDTH bits: operand B; latched with start.
REQ-009 Port busy, output, 1 bit: high while a compare is in progress (state BUSY).
REQ-010 Port done, output, 1 bit: single-cycle pulse, high when y holds a new result.
REQ-011 Port y, output, 3 bits: y[2] = A>B, y[1] = A<B, y[0] = A==B; registered.

Function
REQ-012 The FSM SHALL have three states, IDLE, BUSY and DONE, and SHALL use one-hot or binary encoding from the shared package.
REQ-013 In IDLE with start=1, the block SHALL latch a, b and signed_mode into working registers and enter BUSY on the next edge.
REQ-014 In signed mode, the block SHALL invert the MSB of both latched operands so that the unsigned slice compare yields the signed order.
REQ-015 Each BUSY cycle SHALL compare the top DIGIT bits of the working A and B; if they are unequal, the block SHALL register the gt/lt result into y and enter DONE.
REQ-016 If the slices are equal and this is not slice NSLICE-1, both working registers SHALL shift left by DIGIT and a slice counter SHALL increment.
REQ-017 If slice NSLICE-1 is equal, the block SHALL register y=001 and enter DONE.
REQ-018 Latency: with start sampled at edge 0 and k slices examined (1..NSLICE), done SHALL be high in cycle k+1; the worst case is NSLICE+1.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, after which the block SHALL return to IDLE.
REQ-020 y SHALL be exactly one-hot from the first DONE cycle and SHALL hold its value until the next accepted compare completes.
REQ-021 start SHALL be ignored in BUSY and DONE (no queuing), and a, b and signed_mode changes SHALL be ignored while not in IDLE.
REQ-022 busy SHALL be 1 only in BUSY, and done SHALL be 1 only in DONE; busy and done SHALL never be high simultaneously.
REQ-023 The slice counter SHALL be sized to hold NSLICE-1 without wrap; it SHALL clear on acceptance.

Reset
REQ-024 rst=1 SHALL force, at the next edge, state=IDLE, busy=0, done=0, y=000, slice counter=0, and working registers=0.
REQ-025 rst asserted mid-compare SHALL abort the compare with no done pulse; rst has priority over start.
REQ-026 start sampled in the same cycle as rst SHALL be discarded.

Structure
REQ-027 Package comp_pkg SHALL hold the state typedef (IDLE/BUSY/DONE) and the y bit-index constants GT=2, LT=1 and EQ=0.
REQ-028 Sub-module comp_slice SHALL be a combinational DIGIT-bit unsigned comparator producing gt/lt/eq, instantiated once.
REQ-029 The block SHALL contain no latches, and all outputs SHALL be driven from registers.
REQ-030 The target size SHALL be 120-400 lines of RTL in total.

Verification (WIDTH=16, DIGIT=4)
REQ-031 Unsigned, a=0x1234, b=0x1234, start at cycle 0 -> busy in cycles 1-4, done in cycle 5, y=001.
REQ-032 Unsigned, a=0x8000, b=0x7FFF -> done in cycle 2, y=100; repeated with signed_mode=1 -> done in cycle 2, y=010.
REQ-033 Unsigned, a=0x1235, b=0x1234 -> done in cycle 5, y=100; signed, a=0xFFFF (-1), b=0xFFFE (-2) -> done in cycle 5, y=100.
REQ-034 start pulsed with new operands during BUSY -> the pulse is ignored and the result matches the first operands; y holds through the following IDLE cycles.
REQ-035 rst asserted in cycle 2 of a 4-slice compare -> no done pulse; y=000 and busy=0 from the next edge; a new start is accepted afterwards.
REQ-036 Random sweep of 10k operand pairs in both modes -> y matches a reference >/</== each time, and latency matches REQ-018.
